// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one decoder.
// Guard gap between dwells, leading-zero suppression, per-digit blink, frame-aligned loads.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic                    load_ack,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [3:0]              nibble_out,
    output logic                    blank_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_start
);
    localparam int unsigned MAX_LEN = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int unsigned SLOT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW      = 4 * NUM_DIGITS;

    localparam logic [SLOT_W-1:0] GUARD_LAST = SLOT_W'(GUARD_CYCLES - 1);
    localparam logic [SLOT_W-1:0] DWELL_LAST = SLOT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

    typedef enum logic {StGuard, StDrive} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [FRM_W-1:0]    frame_q, frame_d;
    logic                blink_phase_q, blink_phase_d;
    logic [DW-1:0]       shadow_q, shadow_d;
    logic [DW-1:0]       staging_q, staging_d;
    logic                pending_q, pending_d;

    logic                load_ack_d, frame_start_d, blank_out_d;
    logic [3:0]          nibble_out_d;
    logic [NUM_DIGITS-1:0] digit_en_n_d;

    logic                slot_end, boundary;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                all_zero, mask_bit, lz_bit;

    // State register; outputs are registered from the next-state view so they match state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StGuard;
            idx_q         <= '0;
            slot_q        <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= '0;
            staging_q     <= '0;
            pending_q     <= 1'b0;
            load_ack      <= 1'b0;
            frame_start   <= 1'b0;
            blank_out     <= 1'b1;
            nibble_out    <= 4'h0;
            digit_en_n    <= '1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            slot_q        <= slot_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            staging_q     <= staging_d;
            pending_q     <= pending_d;
            load_ack      <= load_ack_d;
            frame_start   <= frame_start_d;
            blank_out     <= blank_out_d;
            nibble_out    <= nibble_out_d;
            digit_en_n    <= digit_en_n_d;
        end
    end

    // Next-state logic: scan sequencing, frame counting and the load handshake.
    always_comb begin
        slot_end = (state_q == StGuard) ? (slot_q == GUARD_LAST) : (slot_q == DWELL_LAST);
        boundary = (state_q == StDrive) && slot_end && (idx_q == IDX_LAST);

        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q + 1'b1;
        if (slot_end) begin
            slot_d = '0;
            if (state_q == StGuard) begin
                state_d = StDrive;
            end else begin
                state_d = StGuard;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end

        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        staging_d     = staging_q;
        pending_d     = pending_q;
        if (boundary) begin
            if (frame_q == FRM_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
            if (pending_q) begin
                shadow_d  = staging_q;
                pending_d = 1'b0;
            end
        end
        // A load coinciding with a commit is staged for the following frame.
        if (load) begin
            staging_d = digits_in;
            pending_d = 1'b1;
        end
    end

    // Output logic, evaluated on the state being entered.
    always_comb begin
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero & (shadow_d[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz & all_zero & (i != 0);
        end

        nibble_out_d = 4'h0;
        mask_bit     = 1'b0;
        lz_bit       = 1'b0;
        digit_en_n_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble_out_d = shadow_d[4*i +: 4];
                mask_bit     = blink_mask[i];
                lz_bit       = lz_blank[i];
                if (state_d == StDrive) begin
                    digit_en_n_d[i] = 1'b0;
                end
            end
        end

        blank_out_d   = (state_d == StGuard) ? 1'b1 : (lz_bit | (blink_phase_d & mask_bit));
        frame_start_d = boundary;
        load_ack_d    = boundary & pending_q;
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a 20-cycle frame (4 digits x (1 guard + 4 dwell)).
module tb_seven_seg_scanner;
    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [3:0]  nibble_out;
    logic        blank_out;
    logic [3:0]  digit_en_n;
    logic        frame_start;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int acks    = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(4),
        .GUARD_CYCLES(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .load_ack   (load_ack),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .nibble_out (nibble_out),
        .blank_out  (blank_out),
        .digit_en_n (digit_en_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Leaves the bench at cycle 0: the last reset cycle, rst_n released for the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic load_at(input int c, input logic [15:0] v);
        goto(c);
        digits_in = v;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_en;
        int p;
        rst_n      = 1'b0;
        digits_in  = '0;
        load       = 1'b0;
        blink_mask = '0;
        blank_lz   = 1'b0;

        // 1. Reset release and one full scan.
        do_reset();
        chk("rst_ack", load_ack, 1'b0);
        for (int c = 0; c <= 20; c++) begin
            goto(c);
            p      = c % 20;
            exp_en = (p % 5 == 0) ? 4'hF : ~(4'h1 << (p / 5));
            chk("scan_en", digit_en_n, exp_en);
            chk("scan_fs", frame_start, c == 20);
            chk("scan_nib", nibble_out, 4'h0);
            if (p % 5 == 0) chk("scan_guard_blank", blank_out, 1'b1);
        end

        // 2. Mid-frame load commits only at the boundary.
        do_reset();
        load_at(7, 16'h1234);
        goto(19);
        chk("ld_pre_nib", nibble_out, 4'h0);
        chk("ld_pre_ack", load_ack, 1'b0);
        goto(20);
        chk("ld_ack", load_ack, 1'b1);
        chk("ld_fs", frame_start, 1'b1);
        chk("ld_g0_nib", nibble_out, 4'h4);
        goto(21);
        chk("ld_ack_pulse", load_ack, 1'b0);
        goto(22); chk("ld_d0", nibble_out, 4'h4);
        goto(27); chk("ld_d1", nibble_out, 4'h3);
        goto(32); chk("ld_d2", nibble_out, 4'h2);
        goto(37); chk("ld_d3", nibble_out, 4'h1);
        chk("ld_d3_en", digit_en_n, 4'b0111);

        // 3. Leading-zero suppression.
        blank_lz = 1'b1;
        load_at(38, 16'h0050);
        goto(42); chk("lz_d0_nib", nibble_out, 4'h0); chk("lz_d0_blank", blank_out, 1'b0);
        goto(47); chk("lz_d1_nib", nibble_out, 4'h5); chk("lz_d1_blank", blank_out, 1'b0);
        goto(52); chk("lz_d2_blank", blank_out, 1'b1);
        goto(57); chk("lz_d3_blank", blank_out, 1'b1);
        load_at(58, 16'h0000);
        goto(62); chk("lz0_d0_blank", blank_out, 1'b0);
        goto(67); chk("lz0_d1_blank", blank_out, 1'b1);
        goto(72); chk("lz0_d2_blank", blank_out, 1'b1);
        goto(77); chk("lz0_d3_blank", blank_out, 1'b1);
        blank_lz = 1'b0;

        // 4. Blink on digit 2, two frames per half-period, counted from reset.
        blink_mask = 4'b0100;
        do_reset();
        load_at(1, 16'h1234);
        for (int f = 0; f < 6; f++) begin
            goto(20 * f + 2);  chk("blk_d0", blank_out, 1'b0);
            goto(20 * f + 7);  chk("blk_d1", blank_out, 1'b0);
            goto(20 * f + 12); chk("blk_d2", blank_out, (f == 2 || f == 3));
            goto(20 * f + 17); chk("blk_d3", blank_out, 1'b0);
        end
        blink_mask = 4'b0000;

        // 5. Last load wins; load on the committing edge is staged for the next frame.
        load_at(122, 16'h1111);
        load_at(125, 16'h2222);
        load_at(139, 16'h3333);
        chk("mul_ack0", load_ack, 1'b1);
        chk("mul_fs0", frame_start, 1'b1);
        goto(142); chk("mul_nib0", nibble_out, 4'h2);
        acks = 0;
        for (int c = 141; c < 160; c++) begin
            goto(c);
            if (load_ack) acks++;
        end
        chk("mul_no_extra_ack", acks, 0);
        goto(157); chk("mul_nib3", nibble_out, 4'h2);
        goto(160); chk("mul_ack1", load_ack, 1'b1);
        goto(162); chk("mul_nib1", nibble_out, 4'h3);

        // 6. Reset during DRIVE idx 2 with a load pending.
        load_at(165, 16'h5555);
        goto(171);
        chk("rr_pre_en", digit_en_n, 4'b1011);
        rst_n = 1'b0;
        step();
        chk("rr_en", digit_en_n, 4'hF);
        chk("rr_nib", nibble_out, 4'h0);
        chk("rr_blank", blank_out, 1'b1);
        chk("rr_ack", load_ack, 1'b0);
        chk("rr_fs", frame_start, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        goto(1);  chk("rr_d0_en", digit_en_n, 4'b1110); chk("rr_d0_nib", nibble_out, 4'h0);
        goto(7);  chk("rr_d1_nib", nibble_out, 4'h0);
        goto(12); chk("rr_d2_nib", nibble_out, 4'h0);
        goto(17); chk("rr_d3_nib", nibble_out, 4'h0);
        goto(20);
        chk("rr_bnd_fs", frame_start, 1'b1);
        chk("rr_bnd_ack", load_ack, 1'b0);
        goto(22); chk("rr_next_nib", nibble_out, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
